game_move_ctrl: RTL and testbench
=================================

# game_move_ctrl

Front-end controller that sits between the four raw direction buttons and the adventure-game room FSM (`game`). It synchronises and debounces each button and arbitrates simultaneous presses. For each press-and-release it issues exactly one single-cycle move pulse on `n`/`e`/`s`/`w`. Once the game reports `win` or `die`, it locks out all further moves until reset.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4, is the number of consecutive cycles a synchronised level must differ from the debounced level before the debounced level flips. Legal range is 1..255.
- `CNT_W`, default 8, is the width of each debounce counter. `2**CNT_W > DEBOUNCE_CYCLES` is required.

Ports:
- `clk`, input, 1 bit: the single clock. All state updates on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset. 0 clears all state.
- `btn_n`, `btn_e`, `btn_s`, `btn_w`, inputs, 1 bit each: raw, asynchronous, active-high buttons.
- `win`, `die`, inputs, 1 bit each: status from `game`. Level-sensitive.
- `n`, `e`, `s`, `w`, outputs, 1 bit each: registered move pulses to `game`. At most one is high in any cycle.
- `locked`, output, 1 bit: high while in state LOCKED.
- `moves`, output, 8 bits: count of issued moves. Saturates at 255.

## Operation
Input path, per button:
- Two-flop synchroniser.
- Debounce counter: cleared whenever the synchronised level equals the debounced level. Otherwise it increments. When it reaches `DEBOUNCE_CYCLES-1` and the levels still differ, the debounced level flips and the counter clears.
- Rise detect: debounced level is 1 and its one-cycle-delayed copy is 0.

Arbiter FSM. States are IDLE, ISSUE, WAIT_RELEASE and LOCKED; reset state is IDLE.
- Any state: if `win` or `die` is 1, the next state is LOCKED. This has priority over every other transition.
- IDLE: if any rise is seen, latch the grant with fixed priority N > E > S > W and go to ISSUE. Other simultaneous rises are discarded.
- ISSUE: drive the granted move output high for this one cycle. Increment `moves` unless it is already 255. Go to WAIT_RELEASE.
- WAIT_RELEASE: go to IDLE once all four debounced levels are 0. Rises seen in this state are ignored, so holding a button never repeats a move.
- LOCKED: all move outputs are 0 and `locked` is 1. The only exit is `reset`.

Outputs are decoded from registered state and grant, so there is no combinational path from the buttons, `win` or `die` to the outputs.

## Timing
- Reset values: `n`=`e`=`s`=`w`=0, `locked`=0, `moves`=0, FSM in IDLE, all debounced levels 0, all counters 0.
- Latency: the raw button is first sampled high at edge k. The debounced level goes to 1 at edge k+1+DEBOUNCE_CYCLES. The FSM enters ISSUE at edge k+2+DEBOUNCE_CYCLES. The move output is high for exactly one cycle and returns low at edge k+3+DEBOUNCE_CYCLES.
- With DEBOUNCE_CYCLES=4, the move output is high in the cycle after edge k+6.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES cycles after synchronisation produces no flip and no move.
- `win`/`die` and a rise at the same edge while in IDLE: the FSM goes to LOCKED and no pulse is issued.
- `win`/`die` during ISSUE: the pulse already in flight completes its single cycle, then the FSM goes to LOCKED.
- `reset` asserted mid-pulse: outputs drop to 0 immediately, without waiting for a clock edge.
- A button held through reset deassertion is treated as a fresh press. It yields one move DEBOUNCE_CYCLES+2 edges after the first sampling edge.
- Minimum spacing between two moves is DEBOUNCE_CYCLES+3 cycles, because release must be debounced before the FSM returns to IDLE.

## Structure
- A shared package `game_pkg` holds:
  - the FSM state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT_RELEASE=2'd2, LOCKED=2'd3;
  - direction index constants: DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3. `game` uses the same constants.
- Sub-module `btn_debounce` contains the synchroniser, counter and debounced level, and outputs the debounced level plus the rise pulse. It is instantiated four times.
- The arbiter FSM, grant register and `moves` counter live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and a 100-unit clock.
- Single press: after reset, `btn_e` goes high at edge 0 and is held 10 cycles. Required: `e` high for exactly 1 cycle following edge 6, `n`/`s`/`w` stay 0, `moves`=1.
- Bounce: `btn_s` toggles 1,0,1,0 on consecutive cycles, then stays 0. Required: no move pulse, `moves` stays 0.
- Simultaneous press: `btn_n` and `btn_w` rise at the same edge and are held. Required: only `n` pulses, once; releasing both then pressing `btn_w` alone gives one `w` pulse; `moves`=2.
- Hold: `btn_e` held for 50 cycles. Required: exactly one `e` pulse. Release then press `btn_e` again: a second pulse, no earlier than 7 cycles after release.
- Lockout: route E, S, W, E, E (mirrors the win path) with `win` driven to 1 after the fifth move. Required: `locked`=1 on the next edge, and a further `btn_n` press produces no pulse. `moves`=5.
- Reset mid-operation: assert `reset`=0 while `s` is high. Required: `s` drops to 0 immediately and `moves`=0. After deassertion with `btn_s` still held, one `s` pulse follows 6 edges after the first sampling edge.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared FSM state encoding, direction indices and grant arbitration helper
// Used by game_move_ctrl and by the game room FSM, which indexes moves with the same DIR_* constants.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ISSUE        = 2'd1,
    WAIT_RELEASE = 2'd2,
    LOCKED       = 2'd3
  } state_e;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Fixed priority N > E > S > W; the caller only uses the result when some bit is set.
  function automatic logic [1:0] pick_dir(logic [3:0] r);
    return r[DIR_N] ? DIR_N : r[DIR_E] ? DIR_E : r[DIR_S] ? DIR_S : DIR_W;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, consecutive-cycle debounce counter and rise detect for one button
// Ports: clk, reset (async, active-low), btn (raw async input), level (debounced), rise (one-cycle 0->1 of level)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic sync1_q, sync2_q, level_q, level_d, dly_q, differ, expire;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees; any agreement restarts it,
  // so a flip needs DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    differ = sync2_q != level_q;
    expire = differ && cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
    cnt_d = (!differ || expire) ? '0 : cnt_q + CNT_W'(1);
    level_d = expire ? ~level_q : level_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q <= '0;
      level_q <= 1'b0;
      dly_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      cnt_q <= cnt_d;
      level_q <= level_d;
      dly_q <= level_q;
    end
  end

  assign level = level_q;
  assign rise = level_q & ~dly_q;

endmodule

// File: rtl/game_move_ctrl.sv
// game_move_ctrl: debounces four direction buttons and issues one arbitrated move pulse per press-and-release
// Ports: clk, reset (async, active-low), btn_n/e/s/w (raw buttons), win/die (game status),
//        n/e/s/w (single-cycle move pulses), locked (lockout active), moves (saturating move count)
module game_move_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       btn_e,
  input  logic       btn_s,
  input  logic       btn_w,
  input  logic       win,
  input  logic       die,
  output logic       n,
  output logic       e,
  output logic       s,
  output logic       w,
  output logic       locked,
  output logic [7:0] moves
);

  logic [3:0] btn_v, level_v, rise_v;
  state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [7:0] moves_q, moves_d;
  logic issue;

  // Bit positions follow the DIR_* indices so the grant can index directly.
  assign btn_v = {btn_w, btn_s, btn_e, btn_n};

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_db (
      .clk(clk),
      .reset(reset),
      .btn(btn_v[i]),
      .level(level_v[i]),
      .rise(rise_v[i])
    );
  end

  // win/die overrides everything; LOCKED falls through to hold because no other term matches it.
  // Rises outside IDLE are dropped, which is what stops a held button from repeating.
  always_comb begin
    state_d = (win || die) ? LOCKED :
              (state_q == IDLE && |rise_v) ? ISSUE :
              (state_q == ISSUE) ? WAIT_RELEASE :
              (state_q == WAIT_RELEASE && level_v == 4'b0) ? IDLE : state_q;
    grant_d = (state_q == IDLE && |rise_v) ? pick_dir(rise_v) : grant_q;
    moves_d = (state_q == ISSUE && moves_q != 8'hff) ? moves_q + 8'd1 : moves_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= DIR_N;
      moves_q <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      moves_q <= moves_d;
    end
  end

  // Pure decode of registers: reset clears them asynchronously, so pulses drop without a clock edge.
  assign issue = state_q == ISSUE;
  assign n = issue && grant_q == DIR_N;
  assign e = issue && grant_q == DIR_E;
  assign s = issue && grant_q == DIR_S;
  assign w = issue && grant_q == DIR_W;
  assign locked = state_q == LOCKED;
  assign moves = moves_q;

endmodule

// File: tb/tb_game_move_ctrl.sv
// tb_game_move_ctrl: table vectors, directed corner sequences and randomized presses against a timing model
module tb_game_move_ctrl;

  localparam int D = 4;
  localparam int LAT = D + 3;

  logic clk = 1'b0;
  logic reset, btn_n, btn_e, btn_s, btn_w, win, die;
  logic n, e, s, w, locked;
  logic [7:0] moves;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int pulse_cnt, first_cyc, exp_moves;
  logic [3:0] seen;
  bit chk_en = 0;
  int exp_pulse[int];

  typedef struct {
    logic [3:0] mask;
    int hold;
    logic [3:0] exp_lines;
    int exp_cnt;
  } vec_t;

  vec_t tbl[8];

  game_move_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .btn_n(btn_n), .btn_e(btn_e), .btn_s(btn_s), .btn_w(btn_w),
    .win(win), .die(die),
    .n(n), .e(e), .s(s), .w(w),
    .locked(locked), .moves(moves)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int first_dir(logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [3:0] o, x;
    o = {w, s, e, n};
    if (o != 4'b0) begin
      if (pulse_cnt == 0) first_cyc = cyc;
      pulse_cnt++;
      seen |= o;
    end
    if (chk_en) begin
      x = exp_pulse.exists(cyc) ? 4'(1 << exp_pulse[cyc]) : 4'b0;
      chk("rand_outputs", int'(o), int'(x));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(logic [3:0] m);
    {btn_w, btn_s, btn_e, btn_n} = m;
  endtask

  task automatic clear_mon();
    pulse_cnt = 0;
    first_cyc = -1;
    seen = 4'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_btn(4'b0);
    win = 1'b0;
    die = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    exp_moves = 0;
    clear_mon();
  endtask

  task automatic press(logic [3:0] m, int hold, int after);
    set_btn(m);
    repeat (hold) tick();
    set_btn(4'b0);
    repeat (after) tick();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, r0, ng;
    logic [3:0] m;
    tbl[0] = '{4'b0010, 10, 4'b0010, 1};
    tbl[1] = '{4'b1001, 10, 4'b0001, 1};
    tbl[2] = '{4'b1000, 10, 4'b1000, 1};
    tbl[3] = '{4'b0100, D - 1, 4'b0000, 0};
    tbl[4] = '{4'b0100, D, 4'b0100, 1};
    tbl[5] = '{4'b1110, 6, 4'b0010, 1};
    tbl[6] = '{4'b1100, 8, 4'b0100, 1};
    tbl[7] = '{4'b0001, 1, 4'b0000, 0};
    clear_mon();
    reset = 1'b0;
    set_btn(4'b0);
    win = 1'b0;
    die = 1'b0;
    #120;
    chk("rst_outputs", int'({w, s, e, n}), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_moves", int'(moves), 0);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      clear_mon();
      e0 = cyc;
      press(tbl[i].mask, tbl[i].hold, 25);
      exp_moves += tbl[i].exp_cnt;
      chk($sformatf("tbl%0d_count", i), pulse_cnt, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_lines", i), int'(seen), int'(tbl[i].exp_lines));
      if (tbl[i].exp_cnt > 0) chk($sformatf("tbl%0d_latency", i), first_cyc - e0, LAT);
      chk($sformatf("tbl%0d_moves", i), int'(moves), exp_moves);
    end

    clear_mon();
    set_btn(4'b0100); tick();
    set_btn(4'b0000); tick();
    set_btn(4'b0100); tick();
    set_btn(4'b0000);
    repeat (20) tick();
    chk("bounce_count", pulse_cnt, 0);
    chk("bounce_moves", int'(moves), exp_moves);

    do_reset();
    e0 = cyc;
    press(4'b0010, 50, 0);
    r0 = cyc;
    chk("hold_count", pulse_cnt, 1);
    chk("hold_latency", first_cyc - e0, LAT);
    repeat (D + 2) tick();
    clear_mon();
    press(4'b0010, 6, 20);
    chk("hold_repress_count", pulse_cnt, 1);
    chk("hold_spacing", int'(first_cyc - r0 >= 7), 1);
    chk("hold_moves", int'(moves), 2);

    do_reset();
    press(4'b0010, 6, 14);
    press(4'b0100, 6, 14);
    press(4'b1000, 6, 14);
    press(4'b0010, 6, 14);
    press(4'b0010, 6, 14);
    chk("route_count", pulse_cnt, 5);
    win = 1'b1;
    tick();
    chk("lock_locked", int'(locked), 1);
    win = 1'b0;
    clear_mon();
    press(4'b0001, 8, 20);
    chk("lock_no_pulse", pulse_cnt, 0);
    chk("lock_moves", int'(moves), 5);
    chk("lock_sticky", int'(locked), 1);

    do_reset();
    e0 = cyc;
    set_btn(4'b0001);
    while (cyc < e0 + LAT - 1) tick();
    die = 1'b1;
    repeat (10) tick();
    set_btn(4'b0);
    repeat (10) tick();
    chk("die_same_edge_pulse", pulse_cnt, 0);
    chk("die_same_edge_locked", int'(locked), 1);
    chk("die_same_edge_moves", int'(moves), 0);

    do_reset();
    e0 = cyc;
    set_btn(4'b1000);
    while (cyc < e0 + LAT) tick();
    win = 1'b1;
    repeat (10) tick();
    set_btn(4'b0);
    repeat (10) tick();
    chk("win_issue_pulse", pulse_cnt, 1);
    chk("win_issue_lines", int'(seen), 8);
    chk("win_issue_moves", int'(moves), 1);
    chk("win_issue_locked", int'(locked), 1);

    do_reset();
    press(4'b0010, 6, 14);
    e0 = cyc;
    set_btn(4'b0100);
    while (cyc < e0 + LAT) tick();
    #20;
    chk("rst_mid_s_high", int'(s), 1);
    chk("rst_mid_moves_before", int'(moves), 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_s_drop", int'(s), 0);
    chk("rst_mid_moves", int'(moves), 0);
    #20;
    reset = 1'b1;
    clear_mon();
    e0 = cyc;
    repeat (20) tick();
    chk("rst_held_count", pulse_cnt, 1);
    chk("rst_held_latency", first_cyc - e0, LAT);
    chk("rst_held_lines", int'(seen), 4);
    set_btn(4'b0);

    do_reset();
    exp_pulse.delete();
    chk_en = 1;
    ng = 20;
    for (int g = 0; g < ng; g++) begin
      repeat (D + 2) tick();
      if ($urandom_range(0, 1) == 1) begin
        set_btn(4'($urandom_range(1, 15)));
        repeat ($urandom_range(1, D - 1)) tick();
        set_btn(4'b0);
        repeat (D + 2) tick();
      end
      m = 4'($urandom_range(1, 15));
      exp_pulse[cyc + LAT] = first_dir(m);
      press(m, $urandom_range(D + 1, 12), 0);
    end
    repeat (20) tick();
    chk_en = 0;
    chk("rand_moves", int'(moves), ng);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
